// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter with an 8-entry FIFO on the 6502 core bus.
// Optional macro UART_TX_PARITY_EN inserts a parity bit and adds the CTRL.ODD bit.
module uart_tx_port #(
    parameter logic [15:0] BASE       = 16'hD000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  DIV_INIT   = 8'd9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RW,
    input  logic [15:0] AD,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        hit,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic [7:0]  r_div, r_reload, r_cnt, r_shift;
    logic [2:0]  r_bitn;
    logic        r_en, r_ovf, r_tx;
`ifdef UART_TX_PARITY_EN
    logic        r_odd, r_par;
`endif

    logic        w_sel, w_wr, w_rd, w_full, w_empty, w_push, w_pop;
    logic        w_shift, w_bit_end, w_tx_nxt, w_busy;
    logic [7:0]  w_head, w_rdata, w_ctrl;

    assign w_sel     = (AD[15:2] == BASE[15:2]);
    assign w_wr      = w_sel && !RW;
    assign w_rd      = w_sel && RW;
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push    = w_wr && (AD[1:0] == 2'd0) && !w_full;
    assign w_head    = r_mem[r_rptr[AW-1:0]];
    assign w_bit_end = (r_cnt == 8'd0);
    assign w_busy    = (r_state != S_IDLE);
    assign tx        = r_tx;

`ifdef UART_TX_PARITY_EN
    assign w_ctrl = {6'd0, r_odd, r_en};
`else
    assign w_ctrl = {7'd0, r_en};
`endif

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr[AW-1:0]] <= D_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Register file writes; a DATA write into a full FIFO only flags overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= DIV_INIT;
            r_en  <= 1'b1;
            r_ovf <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_odd <= 1'b0;
`endif
        end else if (w_wr) begin
            case (AD[1:0])
                2'd0: if (w_full) r_ovf <= 1'b1;
                2'd1: if (D_in[3]) r_ovf <= 1'b0;
                2'd2: r_div <= D_in;
                default: begin
                    r_en <= D_in[0];
`ifdef UART_TX_PARITY_EN
                    r_odd <= D_in[1];
`endif
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (AD[1:0])
            2'd0: w_rdata = 8'h00;
            2'd1: w_rdata = {4'd0, r_ovf, w_busy, w_empty, w_full};
            2'd2: w_rdata = r_div;
            default: w_rdata = w_ctrl;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            D_out <= 8'h00;
            hit   <= 1'b0;
        end else begin
            D_out <= w_rd ? w_rdata : 8'h00;
            hit   <= w_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // tx is registered from the next-state decode so the line never glitches.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        w_tx_nxt    = r_tx;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (r_en && !w_empty) begin
                    w_state_nxt = S_START;
                    w_pop       = 1'b1;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_shift     = 1'b1;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bitn == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_par ^ r_odd;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_shift  = 1'b1;
                        w_tx_nxt = r_shift[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_en && !w_empty) begin
                        w_state_nxt = S_START;
                        w_pop       = 1'b1;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // DIV is captured into r_reload only when a frame starts.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift  <= w_head;
            r_reload <= r_div;
            r_cnt    <= r_div;
            r_bitn   <= 3'd0;
`ifdef UART_TX_PARITY_EN
            r_par    <= ^w_head;
`endif
        end else begin
            if (w_shift)
                r_shift <= {1'b0, r_shift[7:1]};
            if (r_state != S_IDLE)
                r_cnt <= w_bit_end ? r_reload : r_cnt - 8'd1;
            if (r_state == S_DATA && w_bit_end)
                r_bitn <= r_bitn + 3'd1;
        end
    end
endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped UART transmitter on the 6502 `core` data bus, downstream of the CPU alongside `ram`. It decodes a 4-byte register window from the core's 16-bit address bus and accepts bytes written by the CPU into an 8-entry FIFO. It serializes those bytes 8N1 on `tx`, LSB first. It returns status and register data to the core's read-data mux, using the same one-cycle read latency as `ram`.

## Interface
- `BASE`, 16'hD000, window base address; bits [1:0] must be 0.
- `FIFO_DEPTH`, 8, transmit FIFO entries; must be a power of two.
- `DIV_INIT`, 8'd9, reset value of DIV; bit period = DIV+1 clocks.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `RW`  in  1  core bus direction: 1 = read, 0 = write.
- `AD`  in  16  core address.
- `D_in`  in  8  write data from the core's `D_out`.
- `D_out`  out  8  registered read data to the core's read mux.
- `hit`  out  1  registered; 1 when `D_out` holds data from this block for the previous cycle's address.
- `tx`  out  1  serial line; idles high.

## Operation
- Address decode: `sel = (AD[15:2] == BASE[15:2])`, with offset `AD[1:0]`.
- Registers:
  - 0 DATA: a write pushes `D_in` to the FIFO; a read returns 8'h00.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits 7:4 = 0. Writing 1 to bit3 clears overflow.
  - 2 DIV: read/write, 8-bit.
  - 3 CTRL: bit0 EN, reset value 1. Other bits read 0, and writes to them are ignored.
- Write cycle (sel && !RW):
  - The register updates at that clock edge.
  - A DATA write while the FIFO is full is dropped and sets overflow. Fullness is judged before any same-cycle pop.
- Read cycle (sel && RW): `D_out` is loaded with the register value at that edge and `hit` is set to 1. Reads have no side effects.
- Non-selected cycle: `hit` goes to 0. `D_out` is don't-care but is driven to 8'h00.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when `UART_TX_PARITY_EN` is defined).
  - IDLE -> START when EN=1 and the FIFO is not empty. On that transition: pop the head into the shift register and latch DIV into the bit-period counter reload. `tx` goes 0.
  - START -> DATA after DIV+1 clocks. DATA shifts out 8 bits LSB first, each DIV+1 clocks, tracked by a 3-bit bit counter.
  - After bit 7: DATA -> STOP (`tx`=1 for DIV+1 clocks) -> IDLE.
  - Back-to-back frames: STOP may go directly to START when the FIFO is not empty and EN=1. This gives no idle gap between frames.
- DIV is sampled only at frame start. A DIV write mid-frame affects the next frame.
- EN cleared mid-frame: the current frame completes and no further pops occur. The FIFO contents are retained.
- FIFO: circular, with pointers one bit wider than the index; wrap-around at `FIFO_DEPTH` is seamless. A simultaneous push and pop when not full keeps the count unchanged.

## Timing
- Reset values: `tx`=1, `D_out`=8'h00, `hit`=0, FIFO empty, overflow=0, DIV=`DIV_INIT`, EN=1, FSM=IDLE.
- Reset mid-frame: `tx` returns to 1 at the reset edge, the FIFO is emptied, and any partial frame is abandoned.
- Read latency: address presented before edge N gives data on `D_out`/`hit` after edge N (same as `ram`).
- DATA write at edge N into an empty FIFO while IDLE with EN=1:
  - edge N: empty=0.
  - edge N+1: FSM enters START and `tx`=0.
  - edge N+1+(DIV+1): first data bit appears.
- Frame length: 10×(DIV+1) clocks, or 11×(DIV+1) clocks with parity.
- STATUS.busy is 1 from the START entry edge until the edge that returns the FSM to IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP, transmitting even parity (XOR of the 8 data bits) for DIV+1 clocks. CTRL bit1 becomes a read/write ODD bit, reset value 0; when set, the parity bit is inverted.
- Not defined: no PARITY state, 8N1 only, and CTRL bit1 reads 0.

## Test plan
- Reset, then read STATUS at 16'hD001 -> `D_out`=8'h02 and `hit`=1 one cycle later. `tx`=1.
- DIV=9; write 8'hA5 to 16'hD000 -> `tx` shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit for 10 clocks. busy=1 for exactly 100 clocks.
- Write 9 bytes (8'h00..8'h08) with EN=0 -> STATUS=8'h09 (full + overflow). Then set EN=1 -> bytes 00..07 are sent back-to-back with no idle gap. Then write 8'h08 to STATUS -> reads 8'h02.
- Write DIV=3 in the middle of a frame sent at DIV=9 -> the current frame keeps 10-clock bits and the next frame uses 4-clock bits.
- Assert `rst_n`=0 during bit 4 of a frame -> `tx`=1, empty=1, and DIV reads back `DIV_INIT`.
- Read `AD`=16'h0005 (RAM space) -> `hit`=0. With parity enabled, sending 8'h07 gives parity bit 1, and gives 0 when ODD=1.
